latch_arb: RTL and testbench

- Round-robin controller that shares one DW-bit transparent capture latch between NREQ requesters, e.g. per-channel status snapshots read by the host interface.
- Each cycle it grants at most one requester a single-cycle capture, then holds the value until the reader acknowledges.
- Sits between the per-channel snapshot sources and the host register read path.

---
 rtl/latch_arb_pkg.sv | 19 +
 rtl/rr_pick.sv | 43 ++++
 rtl/latch_arb.sv | 145 ++++++++++++++
 tb/tb_latch_arb.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/latch_arb_pkg.sv
// Shared types and helpers for the latch_arb round-robin capture controller.
package latch_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    function automatic int ptr_width(input int nreq);
        return $clog2(nreq);
    endfunction

    // The pointer starts on the last requester so that index 0 wins the first round.
    function automatic int ptr_reset(input int nreq);
        return nreq - 32'sd1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request after 'last', wrapping modulo NREQ.
module rr_pick
    import latch_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int PTR_W = ptr_width(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] last,
    output logic             any,
    output logic [PTR_W-1:0] win
);

    logic [2*NREQ-1:0] dbl_s;
    logic [NREQ-1:0]   rot_s;
    int                pos_s;

    // Rotate the request vector so bit k stands for requester (last+1+k) mod NREQ.
    always_comb begin
        dbl_s = {req, req} >> (int'(last) + 32'sd1);
        rot_s = dbl_s[NREQ-1:0];
    end

    // Scan from the far end so the nearest requester after 'last' is assigned last and wins.
    always_comb begin
        pos_s = 32'sd0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot_s[k]) begin
                pos_s = int'(last) + 32'sd1 + k;
            end else begin
                pos_s = pos_s;
            end
        end
        if (pos_s >= NREQ) begin
            pos_s = pos_s - NREQ;
        end else begin
            pos_s = pos_s;
        end
        any = |rot_s;
        win = PTR_W'(pos_s);
    end

endmodule

// File: rtl/latch_arb.sv
// Round-robin controller sharing one DW-bit capture latch among NREQ requesters.
// Define LATCH_ARB_TIMEOUT_EN to force a release after TIMEOUT unacknowledged HOLD cycles.
module latch_arb
    import latch_arb_pkg::*;
#(
    parameter  int NREQ    = 4,
    parameter  int DW      = 16,
    parameter  int TIMEOUT = 1024,
    localparam int PTR_W   = ptr_width(NREQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] din,
    output logic [NREQ-1:0]    gnt,
    output logic [DW-1:0]      q,
    output logic               valid,
    output logic [PTR_W-1:0]   owner,
    input  logic               rd_ack,
    output logic               timeout
);

    localparam logic [PTR_W-1:0] LAST_RST = PTR_W'(ptr_reset(NREQ));
    localparam logic [NREQ-1:0]  GNT_ONE  = {{(NREQ-1){1'b0}}, 1'b1};

    if (NREQ < 2 || NREQ > 16 || DW < 1 || TIMEOUT < 1) begin : g_param_check
        $error("latch_arb: parameter out of range");
    end

    state_t           state_r;
    logic [PTR_W-1:0] sel_r;
    logic [PTR_W-1:0] last_r;
    logic [PTR_W-1:0] owner_r;
    logic [DW-1:0]    store_r;
    logic [NREQ-1:0]  gnt_r;
    logic             valid_r;

    logic             pick_any_s;
    logic [PTR_W-1:0] pick_win_s;
    logic [DW-1:0]    cap_word_s;
    logic             expire_s;
    logic             release_s;

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req  (req),
        .last (last_r),
        .any  (pick_any_s),
        .win  (pick_win_s)
    );

    // AND-OR capture mux keyed by the registered one-hot grant, so no other slice reaches q.
    always_comb begin
        cap_word_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            cap_word_s = cap_word_s | (din[i*DW +: DW] & {DW{gnt_r[i]}});
        end
    end

`ifdef LATCH_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 32'sd1);

    logic [CNT_W-1:0] cnt_r;

    // HOLD dwell counter, parked at zero outside HOLD so every HOLD entry restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (state_r != ST_HOLD) begin
            cnt_r <= '0;
        end else if (!rd_ack) begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expire_s = (state_r == ST_HOLD) && !rd_ack && (cnt_r == CNT_W'(TIMEOUT - 32'sd1));
`else
    assign expire_s = 1'b0;
`endif

    assign release_s = rd_ack || expire_s;

    // Arbitration FSM; gnt, valid and owner come straight from its registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            sel_r   <= '0;
            last_r  <= LAST_RST;
            owner_r <= '0;
            store_r <= '0;
            gnt_r   <= '0;
            valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_any_s) begin
                        sel_r   <= pick_win_s;
                        gnt_r   <= GNT_ONE << pick_win_s;
                        state_r <= ST_CAPTURE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CAPTURE: begin
                    store_r <= cap_word_s;
                    last_r  <= sel_r;
                    owner_r <= sel_r;
                    gnt_r   <= '0;
                    valid_r <= 1'b1;
                    state_r <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (release_s) begin
                        valid_r <= 1'b0;
                        if (pick_any_s) begin
                            sel_r   <= pick_win_s;
                            gnt_r   <= GNT_ONE << pick_win_s;
                            state_r <= ST_CAPTURE;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    gnt_r   <= '0;
                    valid_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt     = gnt_r;
    assign valid   = valid_r;
    assign owner   = owner_r;
    assign q       = (state_r == ST_CAPTURE) ? cap_word_s : store_r;
    assign timeout = expire_s;

endmodule

// File: tb/tb_latch_arb.sv
// Self-checking bench for latch_arb: directed vector table, corner sequences, random vs model.
module tb_latch_arb;

    localparam int NREQ    = 4;
    localparam int DW      = 16;
    localparam int TIMEOUT = 8;
    localparam int PW      = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] din;
    logic [NREQ-1:0]    gnt;
    logic [DW-1:0]      q;
    logic               valid;
    logic [PW-1:0]      owner;
    logic               rd_ack;
    logic               timeout;

    always #5 clk = ~clk;

    latch_arb #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .din     (din),
        .gnt     (gnt),
        .q       (q),
        .valid   (valid),
        .owner   (owner),
        .rd_ack  (rd_ack),
        .timeout (timeout)
    );

    int errors = 0;
    int checks = 0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 = waiting, 1 = capture cycle, 2 = holding a word
    int            m_phase, m_sel, m_last, m_owner, m_cnt;
    logic [DW-1:0] m_store;

    task automatic model_reset();
        m_phase = 0; m_sel = 0; m_last = NREQ - 1; m_owner = 0; m_cnt = 0; m_store = '0;
    endtask

    function automatic int rr_winner(input logic [NREQ-1:0] r, input int last);
        logic [NREQ-1:0] sh;
        for (int i = 1; i <= NREQ; i++) begin
            sh = r >> ((last + i) % NREQ);
            if (sh[0]) return (last + i) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] slice(input logic [NREQ*DW-1:0] d, input int i);
        logic [NREQ*DW-1:0] t;
        t = d >> (i * DW);
        return t[DW-1:0];
    endfunction

    function automatic logic exp_timeout();
`ifdef LATCH_ARB_TIMEOUT_EN
        return (m_phase == 2) && !rd_ack && (m_cnt == TIMEOUT - 1);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_step();
        int  w;
        logic to;
        to = exp_timeout();
        case (m_phase)
            0: begin
                w = rr_winner(req, m_last);
                if (w >= 0) begin m_sel = w; m_phase = 1; end
            end
            1: begin
                m_store = slice(din, m_sel);
                m_last = m_sel; m_owner = m_sel; m_cnt = 0; m_phase = 2;
            end
            default: begin
                if (rd_ack || to) begin
                    w = rr_winner(req, m_last);
                    if (w >= 0) begin m_sel = w; m_phase = 1; end
                    else m_phase = 0;
                end else begin
                    m_cnt++;
                end
            end
        endcase
    endtask

    task automatic check_model(input string tag);
        logic [NREQ-1:0] eg;
        logic [DW-1:0]   eq;
        eg = (m_phase == 1) ? (4'b0001 << m_sel) : 4'b0000;
        eq = (m_phase == 1) ? slice(din, m_sel) : m_store;
        cmp({tag, " gnt"}, gnt, eg);
        cmp({tag, " q"}, q, eq);
        cmp({tag, " valid"}, valid, (m_phase == 2));
        cmp({tag, " owner"}, owner, m_owner);
        cmp({tag, " timeout"}, timeout, exp_timeout());
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [NREQ-1:0]    req;
        logic               ack;
        logic [NREQ*DW-1:0] din;
        logic [NREQ-1:0]    gnt;
        logic [DW-1:0]      q;
        logic               valid;
        logic [PW-1:0]      owner;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] r, input logic a, input logic [63:0] d,
                                input logic [3:0] g, input logic [15:0] eq, input logic v,
                                input logic [1:0] o);
        vec_t t;
        t.req = r; t.ack = a; t.din = d; t.gnt = g; t.q = eq; t.valid = v; t.owner = o;
        return t;
    endfunction

    localparam logic [63:0] DIN0 = 64'h3333_A5A5_1111_0000;
    localparam logic [63:0] DIN1 = 64'h3333_1234_1111_0000;

    vec_t vec[16];
    logic seen1;

    initial begin
        vec[0]  = mk(4'b0000, 1'b0, DIN0, 4'b0000, 16'h0000, 1'b0, 2'd0);
        vec[1]  = mk(4'b0100, 1'b0, DIN0, 4'b0000, 16'h0000, 1'b0, 2'd0);
        vec[2]  = mk(4'b0000, 1'b0, DIN0, 4'b0100, 16'hA5A5, 1'b0, 2'd0);
        vec[3]  = mk(4'b0000, 1'b0, DIN1, 4'b0000, 16'hA5A5, 1'b1, 2'd2);
        vec[4]  = mk(4'b0000, 1'b0, DIN1, 4'b0000, 16'hA5A5, 1'b1, 2'd2);
        vec[5]  = mk(4'b0000, 1'b1, DIN0, 4'b0000, 16'hA5A5, 1'b1, 2'd2);
        vec[6]  = mk(4'b1111, 1'b0, DIN0, 4'b0000, 16'hA5A5, 1'b0, 2'd2);
        vec[7]  = mk(4'b1111, 1'b1, DIN0, 4'b1000, 16'h3333, 1'b0, 2'd2);
        vec[8]  = mk(4'b1111, 1'b1, DIN0, 4'b0000, 16'h3333, 1'b1, 2'd3);
        vec[9]  = mk(4'b1111, 1'b0, DIN0, 4'b0001, 16'h0000, 1'b0, 2'd3);
        vec[10] = mk(4'b1111, 1'b1, DIN0, 4'b0000, 16'h0000, 1'b1, 2'd0);
        vec[11] = mk(4'b0010, 1'b0, DIN0, 4'b0010, 16'h1111, 1'b0, 2'd0);
        vec[12] = mk(4'b0010, 1'b1, DIN0, 4'b0000, 16'h1111, 1'b1, 2'd1);
        vec[13] = mk(4'b0010, 1'b0, DIN0, 4'b0010, 16'h1111, 1'b0, 2'd1);
        vec[14] = mk(4'b0000, 1'b1, DIN0, 4'b0000, 16'h1111, 1'b1, 2'd1);
        vec[15] = mk(4'b0000, 1'b0, DIN0, 4'b0000, 16'h1111, 1'b0, 2'd1);

        rst_n = 1'b0; req = '0; rd_ack = 1'b0; din = '0;
        model_reset();
        #12;
        check_model("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 16; k++) begin
            req = vec[k].req; rd_ack = vec[k].ack; din = vec[k].din;
            #1;
            cmp($sformatf("vec%0d gnt", k), gnt, vec[k].gnt);
            cmp($sformatf("vec%0d q", k), q, vec[k].q);
            cmp($sformatf("vec%0d valid", k), valid, vec[k].valid);
            cmp($sformatf("vec%0d owner", k), owner, vec[k].owner);
            cmp($sformatf("vec%0d timeout", k), timeout, 1'b0);
            tick();
        end

        // Reset while holding a word: everything returns to reset values at once.
        rd_ack = 1'b0; din = DIN0; req = 4'b0100;
        #1; check_model("rh0"); tick();
        req = 4'b0000;
        #1; check_model("rh1"); tick();
        cmp("rh hold valid", valid, 1'b1);
        #2; rst_n = 1'b0; #1;
        cmp("rh valid", valid, 1'b0);
        cmp("rh q", q, 16'h0000);
        cmp("rh gnt", gnt, 4'b0000);
        cmp("rh owner", owner, 2'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1; req = 4'b0001;
        #1; check_model("rh2"); tick();
        cmp("rh regrant gnt", gnt, 4'b0001);
        check_model("rh3");
        req = 4'b0000; tick();
        rd_ack = 1'b1; #1; check_model("rh4"); tick();
        rd_ack = 1'b0;

        // Requester 1 drops its request before being granted and must never see gnt.
        seen1 = 1'b0;
        req = 4'b0001; #1; check_model("dr0"); tick();
        seen1 |= gnt[1];
        req = 4'b0110; #1; check_model("dr1"); tick();
        seen1 |= gnt[1];
        #1; check_model("dr2"); tick();
        seen1 |= gnt[1];
        req = 4'b0100; rd_ack = 1'b1; #1; check_model("dr3"); tick();
        seen1 |= gnt[1];
        cmp("dr gnt2", gnt, 4'b0100);
        req = 4'b0000; #1; check_model("dr4"); tick();
        seen1 |= gnt[1];
        #1; check_model("dr5"); tick();
        cmp("dr never granted", seen1, 1'b0);
        rd_ack = 1'b0;

`ifdef LATCH_ARB_TIMEOUT_EN
        // No acknowledge: forced release in the TIMEOUT-th HOLD cycle.
        req = 4'b0001; #1; tick();
        req = 4'b0000; tick();
        for (int h = 1; h <= TIMEOUT; h++) begin
            #1;
            check_model($sformatf("to%0d", h));
            cmp($sformatf("to pulse h%0d", h), timeout, (h == TIMEOUT));
            tick();
        end
        cmp("to back idle", valid, 1'b0);
        // Acknowledge in the expiry cycle wins: no pulse.
        req = 4'b0001; #1; tick();
        req = 4'b0000; tick();
        for (int h = 1; h < TIMEOUT; h++) tick();
        rd_ack = 1'b1; #1;
        cmp("to ack wins", timeout, 1'b0);
        check_model("to ack");
        tick();
        rd_ack = 1'b0;
        cmp("to ack idle", valid, 1'b0);
`else
        // Without the timeout feature HOLD waits indefinitely.
        req = 4'b0001; #1; tick();
        req = 4'b0000; tick();
        for (int h = 0; h < 3 * TIMEOUT; h++) begin
            cmp($sformatf("nt pulse h%0d", h), timeout, 1'b0);
            tick();
        end
        cmp("nt still held", valid, 1'b1);
        rd_ack = 1'b1; tick();
        rd_ack = 1'b0;
`endif

        // Randomised traffic against the model.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 1) == 0) req = 4'($urandom_range(0, 15));
            rd_ack = ($urandom_range(0, 3) == 0);
            din = {$urandom, $urandom};
            #1;
            check_model($sformatf("rnd%0d", c));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
